// File: rtl/toggle_decoder.sv
// Toggle-line frame decoder: NRZI-style toggle decode, sync hunt, payload
// assembly with a one-deep valid/ready output register.
// Ports: clk, rst (async active-low), line_in/line_en (encoded line + strobe),
//   data_out/data_valid/data_ready (byte output), sync_lock, overflow,
//   stuff_err (pulses). Optional macro STUFF_EN enables bit-unstuffing.
module toggle_decoder #(
  parameter logic [7:0] SYNC_WORD = 8'hD3,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  input  logic       line_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       sync_lock,
  output logic       overflow,
  output logic       stuff_err
);

  localparam logic [7:0] LP_LAST = 8'(FRAME_LEN - 1);

  typedef enum logic {S_HUNT, S_DATA} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_prev;
  // Only the upper 7 bits survive the next shift, so bit 0 is not stored.
  logic [7:1] r_sync;
  logic [7:1] r_byte;
  logic [2:0] r_bitcnt;
  logic [7:0] r_bytecnt;
  logic [7:0] r_dout;
  logic       r_valid;
  logic       r_ovf;

  logic       w_dec;
  logic [7:0] w_sync_sh;
  logic [7:0] w_byte_sh;
  logic       w_sync_hit;
  logic       w_accept;
  logic       w_byte_done;
  logic       w_frame_done;
  logic       w_stuff_drop;
  logic       w_stuff_bad;

  assign w_dec     = line_in ^ r_prev;
  assign w_sync_sh = {w_dec, r_sync};
  assign w_byte_sh = {w_dec, r_byte};

`ifdef STUFF_EN
  logic [2:0] r_ones;
  logic       r_serr;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_sync_hit   = 1'b0;
    w_accept     = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_done = 1'b0;
    w_stuff_drop = 1'b0;
    w_stuff_bad  = 1'b0;
    if (line_en) begin
      unique case (r_state)
        S_HUNT: begin
          if (w_sync_sh == SYNC_WORD) begin
            w_sync_hit  = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
`ifdef STUFF_EN
          // Bit after five accepted 1s is a stuff bit; a 1 there is illegal.
          if (r_ones == 3'd5) begin
            w_stuff_drop = 1'b1;
            w_stuff_bad  = w_dec;
          end else begin
            w_accept = 1'b1;
          end
`else
          w_accept = 1'b1;
`endif
          if (w_accept && (r_bitcnt == 3'd7)) begin
            w_byte_done  = 1'b1;
            w_frame_done = (r_bytecnt == LP_LAST);
          end
          if (w_frame_done || w_stuff_bad)
            w_state_nxt = S_HUNT;
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_HUNT;
      r_prev    <= 1'b0;
      r_sync    <= '0;
      r_byte    <= '0;
      r_bitcnt  <= '0;
      r_bytecnt <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (r_valid && data_ready)
        r_valid <= 1'b0;
      if (line_en) begin
        r_prev  <= line_in;
        r_state <= w_state_nxt;
        if (r_state == S_HUNT) begin
          r_sync <= w_sync_sh[7:1];
          if (w_sync_hit) begin
            r_byte    <= '0;
            r_bitcnt  <= '0;
            r_bytecnt <= '0;
          end
        end else begin
          if (w_accept) begin
            r_byte   <= w_byte_sh[7:1];
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          if (w_byte_done) begin
            // Dropped bytes still count toward the frame length.
            r_bytecnt <= r_bytecnt + 8'd1;
            if (!r_valid || data_ready) begin
              r_dout  <= w_byte_sh;
              r_valid <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          if (w_stuff_bad) begin
            r_byte   <= '0;
            r_bitcnt <= '0;
          end
          if (w_state_nxt == S_HUNT)
            r_sync <= '0;
        end
      end
    end
  end

`ifdef STUFF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ones <= '0;
      r_serr <= 1'b0;
    end else begin
      r_serr <= 1'b0;
      if (line_en) begin
        if (w_sync_hit || w_stuff_drop)
          r_ones <= '0;
        else if (w_accept)
          r_ones <= w_dec ? r_ones + 3'd1 : 3'd0;
        if (w_stuff_bad)
          r_serr <= 1'b1;
      end
    end
  end

  assign stuff_err = r_serr;
`else
  assign stuff_err = 1'b0;
`endif

  assign data_out   = r_dout;
  assign data_valid = r_valid;
  assign sync_lock  = (r_state == S_DATA);
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder.
// Drives toggle-encoded frames and checks bytes, handshake and pulses.
module tb_toggle_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_in = 1'b0;
  logic       line_en = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sync_lock;
  logic       overflow;
  logic       stuff_err;

  toggle_decoder dut (
    .clk(clk),
    .rst(rst),
    .line_in(line_in),
    .line_en(line_en),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .sync_lock(sync_lock),
    .overflow(overflow),
    .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

`ifdef STUFF_EN
  localparam int EXP_SERR = 1;
`else
  localparam int EXP_SERR = 0;
`endif

  int         checks = 0;
  int         failures = 0;
  logic       lvl = 1'b0;
  int         ovf_cnt = 0;
  int         serr_cnt = 0;
  logic [7:0] got[$];
  bit         watch_low = 1'b0;
  bit         valid_dropped = 1'b0;

  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (stuff_err) serr_cnt++;
    if (data_valid && data_ready) got.push_back(data_out);
    if (watch_low && !data_valid) valid_dropped = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b, input int gap);
    repeat (gap) begin
      line_en = 1'b0;
      line_in = (($urandom & 32'd1) != 0);
      tick();
    end
    lvl     = lvl ^ b;
    line_in = lvl;
    line_en = 1'b1;
    tick();
    line_en = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] d, input int gap);
    for (int i = 0; i < 8; i++) sbit(d[i], gap);
  endtask

  task automatic sbyte_rdy_last(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) data_ready = 1'b1;
      sbit(d[i], 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(data_valid), 0);
    chk({tag, "_dout"}, 32'(data_out), 0);
    chk({tag, "_lock"}, 32'(sync_lock), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_serr"}, 32'(stuff_err), 0);
  endtask

  initial begin
    #1;
    chk_zero("rst0");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Normal frame, consumer always ready
    data_ready = 1'b1;
    got.delete();
    sbyte(8'hD3, 0);
    chk("t31_lock", 32'(sync_lock), 1);
    for (int k = 1; k <= 4; k++) begin
      sbyte(8'(k), 0);
      chk("t31_valid", 32'(data_valid), 1);
      chk("t31_dout", 32'(data_out), 32'(k));
      chk("t31_lock_k", 32'(sync_lock), (k < 4) ? 1 : 0);
    end
    tick();
    chk("t31_vfall", 32'(data_valid), 0);
    chk("t31_n", 32'(got.size()), 4);
    for (int i = 0; i < got.size(); i++)
      chk("t31_byte", 32'(got[i]), 32'(i + 1));

    // Consumer stalled for the whole frame
    data_ready = 1'b0;
    ovf_cnt = 0;
    sbyte(8'hD3, 0);
    sbyte(8'h01, 0);
    chk("t32_v1", 32'(data_valid), 1);
    chk("t32_d1", 32'(data_out), 8'h01);
    for (int k = 2; k <= 4; k++) begin
      sbyte(8'(k), 0);
      chk("t32_ovf", 32'(overflow), 1);
      chk("t32_dhold", 32'(data_out), 8'h01);
    end
    chk("t32_lock", 32'(sync_lock), 0);
    tick();
    chk("t32_ovf_pulse", 32'(overflow), 0);
    chk("t32_ovf_cnt", 32'(ovf_cnt), 3);
    data_ready = 1'b1;
    tick();
    chk("t32_vfall", 32'(data_valid), 0);

    // Accept coincides with byte-2 completion
    data_ready = 1'b0;
    ovf_cnt = 0;
    sbyte(8'hD3, 0);
    sbyte(8'h01, 0);
    chk("t33_d1", 32'(data_out), 8'h01);
    valid_dropped = 1'b0;
    watch_low = 1'b1;
    sbyte_rdy_last(8'h02);
    chk("t33_d2", 32'(data_out), 8'h02);
    chk("t33_v2", 32'(data_valid), 1);
    chk("t33_ovf", 32'(overflow), 0);
    watch_low = 1'b0;
    chk("t33_nodrop", 32'(valid_dropped), 0);
    sbyte(8'h03, 0);
    sbyte(8'h04, 0);
    chk("t33_lock", 32'(sync_lock), 0);
    tick();
    chk("t33_ovf_cnt", 32'(ovf_cnt), 0);

    // Strobe only every third cycle
    data_ready = 1'b1;
    got.delete();
    sbyte(8'hD3, 2);
    for (int k = 1; k <= 4; k++) sbyte(8'(k), 2);
    tick();
    chk("t35_lock", 32'(sync_lock), 0);
    chk("t35_n", 32'(got.size()), 4);
    for (int i = 0; i < got.size(); i++)
      chk("t35_byte", 32'(got[i]), 32'(i + 1));

    // Asynchronous reset mid-frame with a pending byte
    data_ready = 1'b0;
    sbyte(8'hD3, 0);
    sbyte(8'h01, 0);
    sbit(1'b1, 0);
    sbit(1'b0, 0);
    sbit(1'b1, 0);
    chk("t30_pre", 32'(data_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("t30_async");
    lvl = 1'b0;
    line_in = 1'b0;
    tick();
    rst = 1'b1;
    repeat (16) sbit(1'b0, 0);
    chk("t30_idle_v", 32'(data_valid), 0);
    chk("t30_idle_l", 32'(sync_lock), 0);
    sbyte(8'hD3, 0);
    chk("t30_relock", 32'(sync_lock), 1);
    sbyte(8'h5A, 0);
    chk("t30_dout", 32'(data_out), 8'h5A);

`ifdef STUFF_EN
    rst = 1'b0;
    lvl = 1'b0;
    line_in = 1'b0;
    tick();
    rst = 1'b1;
    data_ready = 1'b1;
    sbyte(8'hD3, 0);
    for (int i = 0; i < 5; i++) sbit(1'b1, 0);
    sbit(1'b0, 0);
    for (int i = 0; i < 3; i++) sbit(1'b1, 0);
    chk("t34_ff", 32'(data_out), 8'hFF);
    chk("t34_ffv", 32'(data_valid), 1);
    sbyte(8'h00, 0);
    for (int i = 0; i < 5; i++) sbit(1'b1, 0);
    chk("t34_noerr", 32'(serr_cnt), 0);
    sbit(1'b1, 0);
    chk("t34_err", 32'(stuff_err), 1);
    chk("t34_lock", 32'(sync_lock), 0);
    tick();
`endif

    chk("serr_total", 32'(serr_cnt), 32'(EXP_SERR));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hD3, the decoded 8-bit pattern that starts a frame.
REQ-002 SHALL have parameter FRAME_LEN, default 4, the number of payload bytes per frame (legal range 1..255).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port line_in  input  1  toggle-encoded line, where a level change encodes 1 and no change encodes 0 (the inverse of a T flip-flop driven by t).
REQ-006 SHALL have port line_en  input  1  bit strobe; line_in is sampled only in cycles where line_en=1.
REQ-007 SHALL have port data_out  output  8  assembled payload byte.
REQ-008 SHALL have port data_valid  output  1  high while data_out holds an unaccepted byte.
REQ-009 SHALL have port data_ready  input  1  consumer accept.
REQ-010 SHALL have port sync_lock  output  1  high while in DATA state.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port stuff_err  output  1  one-cycle pulse on a stuffing violation; tied 0 when STUFF_EN is undefined.

Function
REQ-013 SHALL, on each clk edge with line_en=1, form dec_bit = line_in XOR prev_line, then set prev_line <= line_in.
REQ-014 SHALL leave all state unchanged in cycles with line_en=0.
REQ-015 SHALL implement state machine HUNT -> DATA -> HUNT.
REQ-016 SHALL, in HUNT, shift dec_bit into an 8-bit sync register LSB-first (newest bit at bit 7) and go to DATA in the same edge on which the register equals SYNC_WORD.
REQ-017 SHALL, on entry to DATA, clear the bit counter, byte counter and ones-run counter.
REQ-018 SHALL, in DATA, shift accepted bits LSB-first into a byte register; the 8th bit completes a byte.
REQ-019 SHALL, on byte completion, present data_out with data_valid=1 at the next clk edge (one-cycle latency from the 8th bit's strobe).
REQ-020 SHALL return to HUNT after byte FRAME_LEN completes, clearing the sync register.
REQ-021 SHALL hold data_out and data_valid stable until a cycle with data_valid=1 and data_ready=1; data_valid then falls on the next edge unless a new byte loads.
REQ-022 SHALL, when a byte completes while data_valid=1 and data_ready=0, keep the old byte, drop the new one, pulse overflow, and still count the dropped byte toward FRAME_LEN.
REQ-023 SHALL, when completion and acceptance coincide, load the new byte, keep data_valid=1, and not pulse overflow.
REQ-024 SHALL leave data_out unchanged when data_valid=0.

Reset
REQ-025 SHALL, with rst=0, immediately and independently of clk set: prev_line=0, state=HUNT, all shift registers and counters=0, data_out=8'h00, data_valid=0, sync_lock=0, overflow=0, stuff_err=0.
REQ-026 SHALL, on reset asserted mid-frame, discard the partial byte and any pending byte; decoding resumes in HUNT after release.

Configuration
REQ-027 SHALL, when STUFF_EN is defined, in DATA, discard (not shift, not count) any dec_bit that follows 5 consecutive accepted 1s, then reset the ones-run counter.
REQ-028 SHALL, when STUFF_EN is defined and the discarded bit is 1, pulse stuff_err, drop the partial byte, and return to HUNT.
REQ-029 SHALL, without STUFF_EN, accept every dec_bit, exclude the ones-run logic, and tie stuff_err to 0.

Verification
REQ-030 SHALL cover: rst=0 mid-stream -> all outputs 0 within the same cycle; after release, data_valid stays 0 until a sync is found.
REQ-031 SHALL cover: line toggles encoding 8'hD3 then bytes 8'h01,8'h02,8'h03,8'h04 with data_ready=1 -> four data_valid pulses carrying 01..04, sync_lock falling after the 4th byte.
REQ-032 SHALL cover: data_ready=0 throughout a frame -> data_out=8'h01 held, overflow pulses 3 times, sync_lock still falls after 4 bytes.
REQ-033 SHALL cover: data_ready asserted exactly on the edge byte 2 completes -> data_out changes 01->02, data_valid never drops, no overflow.
REQ-034 SHALL cover, with STUFF_EN: byte 8'hFF sent as five 1s, stuffed 0, three 1s -> data_out=8'hFF; a stuffed 1 instead -> stuff_err pulse and sync_lock=0.
REQ-035 SHALL cover: line_en toggled every 3rd cycle with the same stream as REQ-031 -> identical byte sequence.
